// File: rtl/dht11_pkg.sv
// Shared DHT11 definitions: FSM state encoding, default protocol timing in microseconds,
// and the frame checksum helper. Used by both the responder and the host-side controller.
// No logic of its own; nothing here adds latency or flow control.
package dht11_pkg;

  // Responder protocol states, in the order they occur during one exchange
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_WAIT,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW,
    ST_REARM
  } dht_state_t;

  // Default timing, microseconds
  localparam int unsigned DEF_CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_T_START_MIN_US = 18000;
  localparam int unsigned DEF_T_WAIT_US      = 30;
  localparam int unsigned DEF_T_RESP_US      = 80;
  localparam int unsigned DEF_T_BIT_LOW_US   = 50;
  localparam int unsigned DEF_T_ZERO_US      = 26;
  localparam int unsigned DEF_T_ONE_US       = 70;

  // Microsecond counter width: wide enough for the longest start pulse
  localparam int unsigned US_CNT_W = 16;

  // Frame checksum: byte sum modulo 256, optionally inverted to inject a fault
  function automatic logic [7:0] frame_checksum(input logic [7:0] b0, input logic [7:0] b1,
                                                input logic [7:0] b2, input logic [7:0] b3,
                                                input logic invert);
    logic [7:0] sum;
    sum = b0 + b1 + b2 + b3;
    return invert ? ~sum : sum;
  endfunction

endpackage

// File: rtl/us_timer.sv
// Microsecond timebase: prescaler of US_DIV clocks feeding a saturating microsecond counter.
// tick is high on the last clock of each microsecond; a synchronous clear restarts both stages.
// No backpressure; the count holds at all-ones instead of wrapping.
module us_timer #(
  parameter int unsigned US_DIV = 100,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] us_count
);

  localparam int unsigned    PW         = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(US_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = (presc == PRESC_LAST);

  // Prescaler and saturating microsecond count, both restarted by clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      us_count <= '0;
    end else if (clr) begin
      presc    <= '0;
      us_count <= '0;
    end else if (tick) begin
      presc <= '0;
      if (us_count != '1) us_count <= us_count + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects the host start pulse and answers with a 40-bit frame.
// Response starts T_WAIT_US after host release (plus 2-clock input synchronizer latency).
// No backpressure: once a frame starts it always runs to completion; only reset aborts it.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned US_DIV         = CLK_HZ / 1_000_000,
  parameter int unsigned T_START_MIN_US = DEF_T_START_MIN_US,
  parameter int unsigned T_WAIT_US      = DEF_T_WAIT_US,
  parameter int unsigned T_RESP_US      = DEF_T_RESP_US,
  parameter int unsigned T_BIT_LOW_US   = DEF_T_BIT_LOW_US,
  parameter int unsigned T_ZERO_US      = DEF_T_ZERO_US,
  parameter int unsigned T_ONE_US       = DEF_T_ONE_US
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dht_in,
  output logic       dht_drive_low,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       bad_crc,
  output logic       busy,
  output logic       frame_done,
  output logic       start_err
);

  // A state of N us ends on the tick that would take the count to N,
  // so the state occupies exactly N*US_DIV clocks.
  localparam logic [US_CNT_W-1:0] START_MIN  = US_CNT_W'(T_START_MIN_US);
  localparam logic [US_CNT_W-1:0] LAST_WAIT  = US_CNT_W'(T_WAIT_US - 1);
  localparam logic [US_CNT_W-1:0] LAST_RESP  = US_CNT_W'(T_RESP_US - 1);
  localparam logic [US_CNT_W-1:0] LAST_BLOW  = US_CNT_W'(T_BIT_LOW_US - 1);
  localparam logic [US_CNT_W-1:0] LAST_ZERO  = US_CNT_W'(T_ZERO_US - 1);
  localparam logic [US_CNT_W-1:0] LAST_ONE   = US_CNT_W'(T_ONE_US - 1);

  dht_state_t            state, state_next;
  logic [1:0]            sync;
  logic                  line;
  logic                  tmr_clr;
  logic                  tick;
  logic [US_CNT_W-1:0]   us_count;
  logic [39:0]           frame;
  logic [5:0]            bit_idx;
  logic                  load_frame;
  logic                  load_idx;
  logic                  dec_idx;

  assign line    = sync[1];
  assign tmr_clr = (state_next != state);

  us_timer #(
    .US_DIV (US_DIV),
    .CNT_W  (US_CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .tick     (tick),
    .us_count (us_count)
  );

  // Two-flop synchronizer on the shared line; idles high like the pulled-up pad
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], dht_in};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Frame snapshot and bit pointer; inputs are only looked at on the snapshot cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame   <= '0;
      bit_idx <= '0;
    end else begin
      if (load_frame)
        frame <= {hum_int, hum_dec, temp_int, temp_dec,
                  frame_checksum(hum_int, hum_dec, temp_int, temp_dec, bad_crc)};
      if (load_idx)     bit_idx <= 6'd39;
      else if (dec_idx) bit_idx <= bit_idx - 6'd1;
    end
  end

  // Next-state and outputs; line activity is ignored from WAIT through END_LOW
  always_comb begin
    state_next    = state;
    dht_drive_low = 1'b0;
    busy          = 1'b0;
    frame_done    = 1'b0;
    start_err     = 1'b0;
    load_frame    = 1'b0;
    load_idx      = 1'b0;
    dec_idx       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!line) state_next = ST_HOST_LOW;
      end
      ST_HOST_LOW: begin
        if (line) begin
          if (us_count >= START_MIN) begin
            state_next = ST_WAIT;
          end else begin
            state_next = ST_IDLE;
            start_err  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (tick && us_count == LAST_WAIT) begin
          state_next = ST_RESP_LOW;
          load_frame = 1'b1;
        end
      end
      ST_RESP_LOW: begin
        busy          = 1'b1;
        dht_drive_low = 1'b1;
        if (tick && us_count == LAST_RESP) state_next = ST_RESP_HIGH;
      end
      ST_RESP_HIGH: begin
        busy = 1'b1;
        if (tick && us_count == LAST_RESP) begin
          state_next = ST_BIT_LOW;
          load_idx   = 1'b1;
        end
      end
      ST_BIT_LOW: begin
        busy          = 1'b1;
        dht_drive_low = 1'b1;
        if (tick && us_count == LAST_BLOW) state_next = ST_BIT_HIGH;
      end
      ST_BIT_HIGH: begin
        busy = 1'b1;
        if (tick && us_count == (frame[bit_idx] ? LAST_ONE : LAST_ZERO)) begin
          if (bit_idx != 6'd0) begin
            dec_idx    = 1'b1;
            state_next = ST_BIT_LOW;
          end else begin
            state_next = ST_END_LOW;
          end
        end
      end
      ST_END_LOW: begin
        busy          = 1'b1;
        dht_drive_low = 1'b1;
        if (tick && us_count == LAST_BLOW) begin
          frame_done = 1'b1;
          state_next = ST_REARM;
        end
      end
      ST_REARM: begin
        // Wait for our own trailing low to clear so it is not taken as a new start
        if (line) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the responder end of the single-wire protocol whose host is the dht11 controller inside air_conditioner.
- Detects the host start pulse on the shared data line and answers with the standard 40-bit frame built from register-supplied humidity/temperature values.
- Used in the top-level bench and in loop-back tests on the board. The top-level ties the pad open-drain: pad = dht_drive_low ? 0 : Z, with a pull-up, and dht_in = pad.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- US_DIV, CLK_HZ/1_000_000, clocks per 1 us tick.
- T_START_MIN_US, 18000, minimum host low time accepted as a start request.
- T_WAIT_US, 30, delay from host release to response.
- T_RESP_US, 80, response low time; also response high time.
- T_BIT_LOW_US, 50, low time preceding each bit and ending the frame.
- T_ZERO_US, 26, high time encoding a 0.
- T_ONE_US, 70, high time encoding a 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dht_in  in  1  sampled level of the shared data line
- dht_drive_low  out  1  1 = pull line low; 0 = release
- hum_int  in  8  humidity integer byte
- hum_dec  in  8  humidity decimal byte
- temp_int  in  8  temperature integer byte
- temp_dec  in  8  temperature decimal byte
- bad_crc  in  1  1 = transmit inverted checksum (fault injection)
- busy  out  1  high from host-release detection to end of frame
- frame_done  out  1  one-cycle pulse when END_LOW finishes
- start_err  out  1  one-cycle pulse when host low was too short

Behaviour:
- Reset (async) values: dht_drive_low=0, busy=0, frame_done=0, start_err=0, state=IDLE, counters=0, sync regs=1.
- dht_in passes through a 2-flop synchronizer. Edge and level decisions use the synced value: 2-cycle latency.
- Timer: prescaler plus microsecond counter, both cleared on every state entry. A state lasting N us therefore lasts exactly N*US_DIV clocks.
- States:
  - IDLE: drive 0. Synced line low -> HOST_LOW.
  - HOST_LOW: drive 0, count us while line is low.
    - Line high with count >= T_START_MIN_US -> WAIT; busy=1.
    - Line high with count below the minimum -> IDLE, pulse start_err.
    - Count saturates; it does not wrap.
  - WAIT: drive 0 for T_WAIT_US, then snapshot the frame and go to RESP_LOW.
    - Frame = {hum_int, hum_dec, temp_int, temp_dec, cs}.
    - cs = (sum of the four bytes) mod 256, bitwise inverted if bad_crc.
    - Inputs are not sampled after the snapshot.
  - RESP_LOW: drive 1 for T_RESP_US -> RESP_HIGH.
  - RESP_HIGH: drive 0 for T_RESP_US -> BIT_LOW, bit index 39.
  - BIT_LOW: drive 1 for T_BIT_LOW_US -> BIT_HIGH.
  - BIT_HIGH: drive 0 for T_ONE_US if the frame bit is 1, else T_ZERO_US.
    - Bits are sent MSB first.
    - Index > 0: decrement index -> BIT_LOW.
    - Index = 0 -> END_LOW.
  - END_LOW: drive 1 for T_BIT_LOW_US, then pulse frame_done and go to REARM.
  - REARM: drive 0, busy=0. Wait for synced line high -> IDLE. This prevents the trailing low from being seen as a new start.
- Bus activity from WAIT through END_LOW is ignored; the responder never aborts mid-frame.
- Reset mid-frame releases the line immediately, asynchronously.
- Total response, release to frame_done = 30+80+80+40*50 + sum(bit highs) + 50 us.

Decomposition:
- Shared package dht11_pkg holds the state encoding localparams and the default timing constants (microseconds). The controller and this responder both use it.
- One natural sub-module: us_timer (prescaler + us counter with sync clear and saturating count), reusable by the controller.

Test Plan:
- Host low 18 ms then release; values 0x37,0x00,0x19,0x05 -> response starts 30 us after release; frame bytes 37 00 19 05 55; frame_done pulses once; busy drops.
- Bit timing on the same frame: first bit (0) high = 26 us ±1 clock; bit 2 (1) high = 70 us; every bit low = 50 us exactly (5000 clocks at 100 MHz).
- Host low 10 ms -> start_err pulses 1 cycle; line never driven; state returns to IDLE; a following 18 ms pulse gets a normal response.
- bad_crc=1 with values 0x40,0x00,0x1A,0x00 -> checksum byte 0xA5 (inverted 0x5A).
- Values change during transmission -> transmitted frame equals the snapshot taken at WAIT end.
- Reset asserted during BIT_HIGH of bit 20 -> dht_drive_low=0 combinationally-after-reset edge; busy=0; the next 18 ms start yields a complete frame.
